// File: rtl/sc_decoder_pkg.sv
// Shared definitions for the SC polar decoder stages.
package sc_decoder_pkg;

    // Default code size (N = 2**n) and leaf LLR width
    localparam int unsigned SC_N_DEFAULT     = 3;
    localparam int unsigned SC_LLR_W_DEFAULT = 8;

    // Leaf-stage control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

endpackage

// File: rtl/sc_hard_decision.sv
// Hard decision on one leaf LLR: frozen bits decide 0, otherwise a negative LLR decides 1.
module sc_hard_decision
    import sc_decoder_pkg::*;
#(
    parameter int unsigned LLR_W = SC_LLR_W_DEFAULT
) (
    input  logic [LLR_W-1:0] i_llr,
    input  logic             i_frozen,
    output logic             o_dec
);

    // Zero LLR is treated as non-negative and decides 0
    always_comb begin
        o_dec = 1'b0;
        if (!i_frozen) begin
            o_dec = ($signed(i_llr) < $signed(LLR_W'(0)));
        end
    end

endmodule

// File: rtl/sc_bit_decision_unit.sv
// Leaf stage of the SC decoder: walks the bit index, makes hard decisions,
// streams u_hat and packs the decisions into a codeword with valid/ready.
module sc_bit_decision_unit
    import sc_decoder_pkg::*;
#(
    parameter int unsigned n     = SC_N_DEFAULT,
    parameter int unsigned LLR_W = SC_LLR_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                llr_valid,
    input  logic [LLR_W-1:0]    llr_in,
    output logic [n-1:0]        bit_index,
    output logic                index_valid,
    input  logic                frozen_bit_indication,
    output logic                u_hat,
    output logic                u_hat_valid,
    output logic [(2**n)-1:0]   word_out,
    output logic                word_valid,
    input  logic                word_ready,
    output logic [n:0]          info_cnt,
    output logic                busy
);

    localparam int unsigned N = 2 ** n;
    localparam logic [n-1:0] LAST_IDX = {n{1'b1}};

    state_t           r_state;
    state_t           w_state_next;
    logic [n-1:0]     r_bit_index;
    logic             r_u_hat;
    logic             r_u_hat_valid;
    logic [N-1:0]     r_word_out;
    logic [n:0]       r_info_cnt;
    logic             w_dec;
    logic             w_accept;
    logic             w_launch;

    // An LLR is only consumed while decoding; elsewhere llr_valid is ignored
    assign w_accept = (r_state == ST_DECODE) && llr_valid;
    assign w_launch = (r_state == ST_IDLE) && start;

    sc_hard_decision #(
        .LLR_W (LLR_W)
    ) u_hard_decision (
        .i_llr    (llr_in),
        .i_frozen (frozen_bit_indication),
        .o_dec    (w_dec)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; word_valid is implied by being in ST_OUTPUT
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_accept && (r_bit_index == LAST_IDX)) begin
                    w_state_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (word_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Index counter, decision register, packing register and info-bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_index   <= '0;
            r_u_hat       <= 1'b0;
            r_u_hat_valid <= 1'b0;
            r_word_out    <= '0;
            r_info_cnt    <= '0;
        end else begin
            r_u_hat_valid <= 1'b0;
            if (w_launch) begin
                r_bit_index <= '0;
                r_word_out  <= '0;
                r_info_cnt  <= '0;
            end
            if (w_accept) begin
                r_u_hat                  <= w_dec;
                r_u_hat_valid            <= 1'b1;
                r_word_out[r_bit_index]  <= w_dec;
                // Natural wrap returns the index to 0 after the last bit
                r_bit_index              <= r_bit_index + 1'b1;
                if (!frozen_bit_indication) begin
                    r_info_cnt <= r_info_cnt + 1'b1;
                end
            end
        end
    end

    assign bit_index   = r_bit_index;
    assign index_valid = (r_state == ST_DECODE);
    assign u_hat       = r_u_hat;
    assign u_hat_valid = r_u_hat_valid;
    assign word_out    = r_word_out;
    assign word_valid  = (r_state == ST_OUTPUT);
    assign info_cnt    = r_info_cnt;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sc_bit_decision_unit.sv
// Bench for sc_bit_decision_unit (n=3, LLR_W=8) with a frozen-bit lookup of 8'h17.
module tb_sc_bit_decision_unit;

    localparam int unsigned NB = 3;
    localparam int unsigned NN = 8;
    localparam int unsigned LW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          llr_valid;
    logic [LW-1:0] llr_in;
    logic [NB-1:0] bit_index;
    logic          index_valid;
    logic          frozen_bit_indication;
    logic          u_hat;
    logic          u_hat_valid;
    logic [NN-1:0] word_out;
    logic          word_valid;
    logic          word_ready;
    logic [NB:0]   info_cnt;
    logic          busy;

    logic [NN-1:0] frozen_mask = 8'h17;

    int       n_tests;
    int       n_fail;
    int       uv_cnt;
    logic [7:0] uh_seq;

    // Reference model: transaction-level view of the word being decoded
    int m_phase;   // 0 waiting for start, 1 collecting LLRs, 2 presenting word
    int m_idx;
    int m_cnt;
    bit m_bits[NN];
    bit m_uhat;
    bit m_uvalid;

    sc_bit_decision_unit #(
        .n     (NB),
        .LLR_W (LW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .llr_valid             (llr_valid),
        .llr_in                (llr_in),
        .bit_index             (bit_index),
        .index_valid           (index_valid),
        .frozen_bit_indication (frozen_bit_indication),
        .u_hat                 (u_hat),
        .u_hat_valid           (u_hat_valid),
        .word_out              (word_out),
        .word_valid            (word_valid),
        .word_ready            (word_ready),
        .info_cnt              (info_cnt),
        .busy                  (busy)
    );

    // Frozen_Bit_Register stand-in: combinational lookup, 1 when not valid
    assign frozen_bit_indication = !index_valid || frozen_mask[bit_index];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NN-1:0] m_word();
        logic [NN-1:0] w;
        w = '0;
        for (int i = 0; i < NN; i++) w[i] = m_bits[i];
        return w;
    endfunction

    task automatic m_reset();
        m_phase  = 0;
        m_idx    = 0;
        m_cnt    = 0;
        m_uhat   = 0;
        m_uvalid = 0;
        for (int i = 0; i < NN; i++) m_bits[i] = 0;
    endtask

    task automatic m_step();
        bit fr;
        bit d;
        m_uvalid = 0;
        if (m_phase == 0) begin
            if (start) begin
                m_phase = 1;
                m_idx   = 0;
                m_cnt   = 0;
                for (int i = 0; i < NN; i++) m_bits[i] = 0;
            end
        end else if (m_phase == 1) begin
            if (llr_valid) begin
                fr = frozen_mask[m_idx];
                d  = fr ? 1'b0 : ($signed(llr_in) < 0);
                m_bits[m_idx] = d;
                m_uhat   = d;
                m_uvalid = 1;
                if (!fr) m_cnt++;
                if (m_idx == NN - 1) m_phase = 2;
                m_idx = (m_idx + 1) % NN;
            end
        end else begin
            if (word_ready) m_phase = 0;
        end
    endtask

    // Model advances on the same events as the DUT
    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("bit_index", bit_index, m_idx);
            check("index_valid", index_valid, (m_phase == 1));
            check("u_hat", u_hat, m_uhat);
            check("u_hat_valid", u_hat_valid, m_uvalid);
            check("word_out", word_out, m_word());
            check("word_valid", word_valid, (m_phase == 2));
            check("info_cnt", info_cnt, m_cnt);
            check("busy", busy, (m_phase != 0));
            if (u_hat_valid) begin
                uh_seq[uv_cnt % 8] = u_hat;
                uv_cnt++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_word();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [LW-1:0] v, input int gap);
        llr_valid = 1'b0;
        repeat (gap) tick();
        llr_valid = 1'b1;
        llr_in    = v;
        tick();
        llr_valid = 1'b0;
    endtask

    task automatic accept(input string tag);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_word_valid"}, word_valid, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bit_index"}, bit_index, 0);
        check({tag, "_index_valid"}, index_valid, 0);
        check({tag, "_u_hat"}, u_hat, 0);
        check({tag, "_u_hat_valid"}, u_hat_valid, 0);
        check({tag, "_word_out"}, word_out, 0);
        check({tag, "_word_valid"}, word_valid, 0);
        check({tag, "_info_cnt"}, info_cnt, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    logic [LW-1:0] t2_llr[NN] = '{8'h07, 8'hFF, 8'h80, 8'h00, 8'h03, 8'hFE, 8'h00, 8'h7F};

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        uv_cnt     = 0;
        uh_seq     = '0;
        rst_n      = 1'b0;
        start      = 1'b0;
        llr_valid  = 1'b0;
        llr_in     = '0;
        word_ready = 1'b0;
        repeat (2) tick();
        check_zero("por");
        rst_n = 1'b1;
        tick();

        // 1: eight LLRs of -5 back-to-back
        uv_cnt = 0;
        start_word();
        for (int i = 0; i < NN; i++) feed(8'hFB, 0);
        check("t1_word_valid", word_valid, 1);
        check("t1_word_out", word_out, 8'hE8);
        check("t1_info_cnt", info_cnt, 4);
        check("t1_useq", uh_seq, 8'hE8);
        check("t1_uv_cnt", uv_cnt, 8);
        check("t1_model_word", m_word(), 8'hE8);
        accept("t1");

        // 2: mixed LLRs including zero and extremes
        start_word();
        for (int i = 0; i < NN; i++) feed(t2_llr[i], 0);
        check("t2_word_out", word_out, 8'h20);
        check("t2_info_cnt", info_cnt, 4);
        check("t2_last_u_hat", u_hat, 0);
        check("t2_model_word", m_word(), 8'h20);
        accept("t2");

        // 3: gaps of three idle cycles between LLRs
        uv_cnt = 0;
        start_word();
        for (int i = 0; i < NN; i++) begin
            feed(8'hFB, (i == 0) ? 0 : 3);
            if (i == 3) begin
                repeat (2) tick();
                check("t3_index_stall", bit_index, 4);
            end
        end
        check("t3_word_out", word_out, 8'hE8);
        check("t3_uv_cnt", uv_cnt, 8);
        accept("t3");

        // 4: consumer stalls for ten cycles; start and llr_valid must be ignored
        start_word();
        for (int i = 0; i < NN; i++) feed(8'hFB, 0);
        for (int i = 0; i < 10; i++) begin
            start     = 1'b1;
            llr_valid = i[0];
            llr_in    = 8'h05;
            tick();
            check("t4_hold_valid", word_valid, 1);
            check("t4_hold_word", word_out, 8'hE8);
            check("t4_hold_cnt", info_cnt, 4);
            check("t4_no_strobe", u_hat_valid, 0);
        end
        llr_valid  = 1'b0;
        word_ready = 1'b1;
        tick();
        start      = 1'b0;
        word_ready = 1'b0;
        check("t4_released", word_valid, 0);
        tick();
        check("t4_start_on_handshake_ignored", busy, 0);

        // 5: reset in the middle of a word
        start_word();
        for (int i = 0; i < 4; i++) feed(8'hFB, 0);
        rst_n = 1'b0;
        #1;
        check_zero("t5_rst");
        tick();
        rst_n = 1'b1;
        tick();
        start_word();
        for (int i = 0; i < NN; i++) feed(8'hFB, 0);
        check("t5_fresh_word", word_out, 8'hE8);
        check("t5_fresh_cnt", info_cnt, 4);
        accept("t5");

        // 6: word_ready and llr_valid toggling in IDLE, then start
        uv_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            word_ready = i[0];
            llr_valid  = !i[0];
            llr_in     = 8'hFB;
            tick();
            check("t6_idle_index_valid", index_valid, 0);
        end
        check("t6_idle_no_strobe", uv_cnt, 0);
        word_ready = 1'b0;
        llr_valid  = 1'b0;
        start_word();
        check("t6_first_decode_index_valid", index_valid, 1);
        check("t6_first_decode_index", bit_index, 0);
        for (int i = 0; i < NN; i++) feed(LW'($urandom), 0);
        accept("t6");

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 2000; i++) begin
            start      = ($urandom_range(0, 3) == 0);
            llr_valid  = $urandom_range(0, 1);
            llr_in     = LW'($urandom);
            word_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            tick();
        end
        start      = 1'b0;
        llr_valid  = 1'b0;
        word_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
